// File: rtl/sha256_padder_if.sv
// sha256_padder_if
//   Bundles the two handshakes of the SHA-256 message padder.
//   Message word stream (upstream -> padder):
//     in_valid, in_data[31:0], in_last, in_bytes[1:0]  /  in_ready
//   Padded block stream (padder -> SHA-256 core):
//     blk_valid, blk_data[511:0], blk_first, blk_last  /  blk_ready
//
//   Handshake rule for both streams: a transfer happens on a rising clock
//   edge where valid and ready are both 1. The source holds its payload
//   stable while valid=1 and ready=0. The padder never makes its valid
//   depend on its ready input.
//
//   Modports:
//     master - the message source / block consumer side (testbench, system)
//     slave  - the padder itself
interface sha256_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder
//   Pads a byte-aligned message (stream of 32-bit big-endian words) into
//   complete 512-bit SHA-256 blocks: 0x80 marker, zero fill, 64-bit
//   big-endian bit length. Each block is flagged first/last so the core can
//   choose init or next. A single block register is used; upstream is
//   stalled (in_ready=0) whenever a block is being built or is pending.
//
// Ports
//   clk          in   clock, all state on rising edge
//   reset_n      in   asynchronous active-low reset
//   bus          if   sha256_padder_if.slave (word input / block output)
//   dbg_state_o  out  current FSM state (0 ACCEPT, 1 PAD1, 2 PAD2, 3 EMIT)
//
// Parameters
//   LEN_W  width of the bit-length counter (1..64); zero-extended into
//          words 14/15, wraps mod 2^LEN_W.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  sha256_padder_if.slave    bus,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_PAD1   = 2'd1,
    S_PAD2   = 2'd2,
    S_EMIT   = 2'd3
  } state_t;

  state_t           state_q, state_d;

  // Block register: word 0 is the most significant word of blk_data.
  logic [31:0]      words_q [16];
  logic [31:0]      words_d [16];
  logic [3:0]       word_idx_q, word_idx_d;
  logic [LEN_W-1:0] bit_len_q, bit_len_d;
  logic             first_flag_q, first_flag_d;
  logic             blk_first_q, blk_first_d;
  logic             blk_last_q, blk_last_d;
  // Context carried from the last accepted word into PAD1/PAD2.
  logic [4:0]       fill_start_q, fill_start_d;   // first word PAD1 may clear
  logic             pad_marker_q, pad_marker_d;   // PAD1 writes 0x80000000 at fill_start
  logic             final_q, final_d;             // PAD1 block carries the length
  logic             pad2_pend_q, pad2_pend_d;     // a length-only block follows
  logic             marker_pend_q, marker_pend_d; // that block starts with 0x80000000

  // Decode of the incoming word
  logic             xfer_in;
  logic             xfer_blk;
  logic [2:0]       nbytes;
  logic [31:0]      last_word;
  logic [4:0]       marker_idx;
  logic [63:0]      len64;

  always_comb begin
    xfer_in  = bus.in_valid && (state_q == S_ACCEPT);
    xfer_blk = bus.blk_ready && (state_q == S_EMIT);
    nbytes   = (bus.in_last && (bus.in_bytes != 2'd0)) ? {1'b0, bus.in_bytes} : 3'd4;
    // Bytes past the message end are forced to zero and the marker follows
    // the last data byte when the final word is partial.
    case (bus.in_bytes)
      2'd1:    last_word = {bus.in_data[31:24], 24'h800000};
      2'd2:    last_word = {bus.in_data[31:16], 16'h8000};
      2'd3:    last_word = {bus.in_data[31:8],  8'h80};
      default: last_word = bus.in_data;
    endcase
    // Index of the word that will hold the marker (16 = next block).
    marker_idx = (bus.in_bytes != 2'd0) ? {1'b0, word_idx_q}
                                        : {1'b0, word_idx_q} + 5'd1;
    len64 = 64'(bit_len_q);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_ACCEPT;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCEPT: begin
        if (xfer_in) begin
          if (!bus.in_last) begin
            if (word_idx_q == 4'd15) state_d = S_EMIT;
          end else if (marker_idx == 5'd16) begin
            state_d = S_EMIT;
          end else begin
            state_d = S_PAD1;
          end
        end
      end
      S_PAD1: state_d = S_EMIT;
      S_PAD2: state_d = S_EMIT;
      S_EMIT: begin
        if (xfer_blk) begin
          if (blk_last_q)       state_d = S_ACCEPT;
          else if (pad2_pend_q) state_d = S_PAD2;
          else                  state_d = S_ACCEPT;
        end
      end
      default: state_d = S_ACCEPT;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    bus.in_ready  = (state_q == S_ACCEPT);
    bus.blk_valid = (state_q == S_EMIT);
    dbg_state_o   = state_q;
  end

  always_comb begin
    bus.blk_data = '0;
    for (int j = 0; j < 16; j++) bus.blk_data[511-32*j -: 32] = words_q[j];
    bus.blk_first = blk_first_q;
    bus.blk_last  = blk_last_q;
  end

  // Datapath next-state
  always_comb begin
    for (int j = 0; j < 16; j++) words_d[j] = words_q[j];
    word_idx_d    = word_idx_q;
    bit_len_d     = bit_len_q;
    first_flag_d  = first_flag_q;
    blk_first_d   = blk_first_q;
    blk_last_d    = blk_last_q;
    fill_start_d  = fill_start_q;
    pad_marker_d  = pad_marker_q;
    final_d       = final_q;
    pad2_pend_d   = pad2_pend_q;
    marker_pend_d = marker_pend_q;

    case (state_q)
      S_ACCEPT: begin
        if (xfer_in) begin
          words_d[word_idx_q] = bus.in_last ? last_word : bus.in_data;
          word_idx_d = word_idx_q + 4'd1;
          bit_len_d  = bit_len_q + LEN_W'({nbytes, 3'b000});
          if (!bus.in_last) begin
            if (word_idx_q == 4'd15) begin
              // Full block of message data goes out as-is.
              blk_first_d = first_flag_q;
              blk_last_d  = 1'b0;
              pad2_pend_d = 1'b0;
            end
          end else begin
            fill_start_d  = {1'b0, word_idx_q} + 5'd1;
            pad_marker_d  = (bus.in_bytes == 2'd0);
            final_d       = (marker_idx <= 5'd13);
            pad2_pend_d   = (marker_idx >= 5'd14);
            marker_pend_d = (marker_idx == 5'd16);
            if (marker_idx == 5'd16) begin
              // Message ends exactly on a block boundary: no PAD1 needed.
              blk_first_d = first_flag_q;
              blk_last_d  = 1'b0;
            end
          end
        end
      end
      S_PAD1: begin
        for (int j = 0; j < 16; j++) begin
          if (j >= int'(fill_start_q))
            words_d[j] = (pad_marker_q && (j == int'(fill_start_q))) ? 32'h8000_0000 : 32'h0;
        end
        if (final_q) begin
          words_d[14] = len64[63:32];
          words_d[15] = len64[31:0];
        end
        blk_first_d = first_flag_q;
        blk_last_d  = final_q;
      end
      S_PAD2: begin
        for (int j = 0; j < 16; j++) words_d[j] = 32'h0;
        if (marker_pend_q) words_d[0] = 32'h8000_0000;
        words_d[14]   = len64[63:32];
        words_d[15]   = len64[31:0];
        blk_first_d   = first_flag_q;
        blk_last_d    = 1'b1;
        pad2_pend_d   = 1'b0;
        marker_pend_d = 1'b0;
      end
      S_EMIT: begin
        if (xfer_blk) begin
          first_flag_d = 1'b0;
          if (blk_last_q) begin
            word_idx_d   = 4'd0;
            bit_len_d    = '0;
            first_flag_d = 1'b1;
          end else if (!pad2_pend_q) begin
            word_idx_d = 4'd0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < 16; j++) words_q[j] <= 32'h0;
      word_idx_q    <= 4'd0;
      bit_len_q     <= '0;
      first_flag_q  <= 1'b1;
      blk_first_q   <= 1'b0;
      blk_last_q    <= 1'b0;
      fill_start_q  <= 5'd0;
      pad_marker_q  <= 1'b0;
      final_q       <= 1'b0;
      pad2_pend_q   <= 1'b0;
      marker_pend_q <= 1'b0;
    end else begin
      for (int j = 0; j < 16; j++) words_q[j] <= words_d[j];
      word_idx_q    <= word_idx_d;
      bit_len_q     <= bit_len_d;
      first_flag_q  <= first_flag_d;
      blk_first_q   <= blk_first_d;
      blk_last_q    <= blk_last_d;
      fill_start_q  <= fill_start_d;
      pad_marker_q  <= pad_marker_d;
      final_q       <= final_d;
      pad2_pend_q   <= pad2_pend_d;
      marker_pend_q <= marker_pend_d;
    end
  end

endmodule
